jtsbaskt_sndcmd: RTL

//  Main-CPU side transmitter of the main-to-sound command link. Main CPU writes
//  are buffered in a small FIFO and sent one at a time. For each byte the block

---
 rtl/jtsbaskt_sndcmd.sv | 124 ++++++++++++
 1 files changed

// File: rtl/jtsbaskt_sndcmd.sv
// Main-to-sound command transmitter: buffers main CPU writes in a small FIFO and
// sends each byte as a latch strobe followed by an IRQ pulse, then waits for the sound CPU.
module jtsbaskt_sndcmd #(
    parameter int AW    = 2,
    parameter int ONLEN = 4,
    parameter int TW    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cmd_we,
    input  logic [7:0] main_dout,
    input  logic       snd_ack,
    output logic [7:0] snd_dout,
    output logic       m2s_data,
    output logic       m2s_on,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       ovf,
    output logic       tout
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam int          OW      = (ONLEN > 1) ? $clog2(ONLEN) : 1;
    // Timeout fires on the cen tick that would take tcnt to all-ones
    localparam logic [TW-1:0] TLAST = {{(TW-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {IDLE, LOAD, STB, TRIG, WAIT} state_t;

    state_t          st, st_nx;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     cnt, cnt_nx;
    logic            push, pop;
    logic [OW-1:0]   on_cnt;
    logic [TW-1:0]   tcnt;
    logic            tlast;

    assign push  = cmd_we & ~full;
    assign pop   = (st == LOAD);
    assign tlast = cen && (tcnt == TLAST);

    always_comb begin
        cnt_nx = cnt;
        if (push && !pop)
            cnt_nx = cnt + 1'b1;
        else if (!push && pop)
            cnt_nx = cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= main_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt   <= cnt_nx;
            full  <= (cnt_nx == DEPTH_C);
            empty <= (cnt_nx == '0);
            if (cmd_we && full)
                ovf <= 1'b1;
        end
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE: if (!empty) st_nx = LOAD;
            LOAD: st_nx = STB;
            STB:  st_nx = TRIG;
            TRIG: if (on_cnt == '0) st_nx = WAIT;
            // An ack takes priority over a simultaneous timeout
            WAIT: if (snd_ack || tlast) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            snd_dout <= 8'd0;
            on_cnt   <= '0;
            tcnt     <= '0;
            tout     <= 1'b0;
        end else begin
            st <= st_nx;
            case (st)
                LOAD: snd_dout <= mem[rd_ptr];
                STB:  on_cnt <= OW'(ONLEN - 1);
                TRIG: if (on_cnt != '0) on_cnt <= on_cnt - 1'b1;
                WAIT: begin
                    if (snd_ack) begin
                        tcnt <= '0;
                    end else if (tlast) begin
                        tout <= 1'b1;
                        tcnt <= '0;
                    end else if (cen) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m2s_data = (st == STB);
    assign m2s_on   = (st == TRIG);
    assign busy     = (st != IDLE);

endmodule
